// File: rtl/fp_mem_controller.sv
// Sequencer that reads two float operands from a 32x32 memory, launches the FPU,
// waits (with timeout) for its result and writes it back to the destination word.
module fp_mem_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_src_a,
    input  logic [4:0]  cmd_src_b,
    input  logic [4:0]  cmd_dst,
    output logic [4:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fpu_start,
    output logic        fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  op_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAT_B, EXEC, WAIT, WR} state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [4:0]    src_a_q, src_a_d;
    logic [4:0]    src_b_q, src_b_d;
    logic [4:0]    dst_q, dst_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic [31:0]   res_q, res_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    err_d   = 1'b0;
                    state_d = RD_A;
                end
            end
            RD_A:  state_d = RD_B;
            // Read data lags the address by one cycle, so each operand lands a state later.
            RD_B: begin
                opa_d   = mem_rdata;
                state_d = LAT_B;
            end
            LAT_B: begin
                opb_d   = mem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fpu_done) begin
                    res_d   = fpu_result;
                    state_d = WR;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WR: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            RD_A:    mem_addr = src_a_q;
            RD_B:    mem_addr = src_b_q;
            WR:      mem_addr = dst_q;
            default: mem_addr = '0;
        endcase
    end

    // Write strobe is gated by rst as well so a reset landing in WR never commits a write.
    assign mem_we    = !((state_q == WR) && !rst);
    assign mem_wdata = res_q;
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign fpu_start = (state_q == EXEC);
    assign fpu_op    = op_q;
    assign fpu_a     = opa_q;
    assign fpu_b     = opb_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == WR);
    assign err       = err_q;
    assign op_count  = cnt_q;

endmodule

// File: doc/fp_mem_controller.md
FP_MEM_CONTROLLER -- requirements
Module: fp_mem_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles allowed for an FPU result before abort.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the controller can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 1 bit: FPU operation select, passed through unchanged.
REQ-007 The block SHALL have ports cmd_src_a, cmd_src_b and cmd_dst, input, 5 bits each: operand A, operand B and result word addresses.
REQ-008 The block SHALL have port mem_addr, output, 5 bits: address to the 32x32 float memory.
REQ-009 The block SHALL have port mem_we, output, 1 bit: memory write strobe, active-low (0 = write).
REQ-010 The block SHALL have port mem_wdata, output, 32 bits: write data.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid the cycle after an address is presented.
REQ-012 The block SHALL have ports fpu_start (output, 1 bit), fpu_op (output, 1 bit) and fpu_a/fpu_b (output, 32 bits each): FPU launch and operands.
REQ-013 The block SHALL have ports fpu_done (input, 1 bit) and fpu_result (input, 32 bits): FPU completion and IEEE-754 single result.
REQ-014 The block SHALL have outputs busy (1 bit), done (1 bit, one-cycle pulse), err (1 bit, sticky) and op_count (8 bits, completed operations).

Function
REQ-015 The FSM states SHALL be IDLE, RD_A, RD_B, LAT_B, EXEC, WAIT and WR.
REQ-016 cmd_ready SHALL be 1 only in IDLE; the command is accepted on an edge with cmd_valid=1 and cmd_ready=1, which latches op, src_a, src_b and dst, clears err and moves to RD_A.
REQ-017 RD_A SHALL drive mem_addr=src_a and go to RD_B.
REQ-018 RD_B SHALL drive mem_addr=src_b, latch mem_rdata into operand A and go to LAT_B.
REQ-019 LAT_B SHALL latch mem_rdata into operand B and go to EXEC.
REQ-020 EXEC SHALL assert fpu_start for exactly that one cycle, with fpu_a, fpu_b and fpu_op stable from EXEC until leaving WAIT, then go to WAIT.
REQ-021 WAIT SHALL clear a timeout counter on entry and sample fpu_done each cycle; fpu_done=1 latches fpu_result and goes to WR.
REQ-022 fpu_done SHALL be ignored in every state other than WAIT.
REQ-023 If TIMEOUT WAIT cycles elapse with fpu_done low, the FSM SHALL go to IDLE, set err=1, skip the write and leave op_count unchanged.
REQ-024 WR SHALL drive mem_addr=dst, mem_wdata=latched result and mem_we=0 for exactly one cycle, pulse done=1, increment op_count (wrapping 255->0) and return to IDLE.
REQ-025 mem_we SHALL be 1 in every state except WR; mem_addr SHALL be 0 in IDLE, EXEC and WAIT.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 The latency from the accept edge to WR SHALL be 5+L cycles, where fpu_done is first high L cycles after the EXEC cycle (L>=1).
REQ-028 A command with dst equal to src_a or src_b SHALL be legal, since both reads complete before the write.
REQ-029 Addresses equal to 0 or 31 SHALL need no special handling.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, with mem_we=1, fpu_start=0, done=0, err=0, busy=0, op_count=0 and all latched operands and addresses cleared.
REQ-031 When rst=1 arrives mid-operation, any pending write SHALL be abandoned, and no memory write SHALL occur in the cycle rst rises.
REQ-032 cmd_ready SHALL be 0 while rst=1.

Verification
REQ-033 Add: preload mem[1]=0x40C80000 (6.25) and mem[10]=0x40980000 (4.75); issue op=0, a=1, b=10, dst=2; stub FPU with L=3 returning 0x41300000 -> fpu_a=0x40C80000, fpu_b=0x40980000, WR 8 cycles after accept writes mem[2]=0x41300000, done pulses once, op_count=1.
REQ-034 Self-overwrite: mem[7]=0xBFC00000; issue op=1, a=7, b=7, dst=7; FPU with L=1 returns 0x40100000 -> both operands read 0xBFC00000, mem[7]=0x40100000 after WR.
REQ-035 Timeout: fpu_done held 0 -> exactly 16 WAIT cycles, then IDLE, err=1, no mem_we=0 cycle, op_count unchanged; the next accepted command clears err.
REQ-036 Reset mid-WAIT: assert rst two cycles after fpu_start -> cmd_ready=0, mem_we=1 and busy=0 immediately; after release, fpu_done=1 is ignored and no write occurs.
REQ-037 Backpressure: cmd_valid held high across two back-to-back commands -> the second is accepted only in the cycle after the first's WR, and fpu_done pulses outside WAIT cause no state change.
REQ-038 Counter wrap: 256 completed operations -> op_count returns to 0.
